// File: rtl/instruction_fetch_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_if
//
// Purpose:
//   Bundles every signal that passes between the fetch stage, the instruction
//   memory, the hazard/branch logic and the decode stage. Only the scalar
//   clock and reset live outside the bundle.
//
// Signal summary:
//   Stall, Flush, BranchTaken, BranchTarget  pipeline control into fetch
//   Addr                                     word address to instruction memory
//   Instruction                              word returned by memory (same cycle)
//   IfId_Instr, IfId_PC, IfId_Valid          IF/ID pipeline register contents
//   Halted                                   fetch has reached the halt address
//   FetchCount                               count of valid fetches (optional)
//
// Modports:
//   master  the fetch stage itself
//   slave   the surrounding pipeline and memory
// ---------------------------------------------------------------------------
interface instruction_fetch_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);

  logic              Stall;
  logic              Flush;
  logic              BranchTaken;
  logic [ADDR_W-1:0] BranchTarget;
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] Instruction;
  logic [DATA_W-1:0] IfId_Instr;
  logic [ADDR_W-1:0] IfId_PC;
  logic              IfId_Valid;
  logic              Halted;
  logic [15:0]       FetchCount;

  // The fetch stage consumes control and memory data, and produces the
  // memory address plus the IF/ID register contents.
  modport master (
    input  Stall,
    input  Flush,
    input  BranchTaken,
    input  BranchTarget,
    input  Instruction,
    output Addr,
    output IfId_Instr,
    output IfId_PC,
    output IfId_Valid,
    output Halted,
    output FetchCount
  );

  // Mirror view for whatever drives the fetch stage.
  modport slave (
    output Stall,
    output Flush,
    output BranchTaken,
    output BranchTarget,
    output Instruction,
    input  Addr,
    input  IfId_Instr,
    input  IfId_PC,
    input  IfId_Valid,
    input  Halted,
    input  FetchCount
  );

endinterface

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// Purpose:
//   Fetch stage of the pipelined MIPS core. Owns the program counter, presents
//   it combinationally to the word-addressed instruction memory and captures
//   the returned word into the IF/ID pipeline register. Handles stall, flush,
//   taken-branch redirect and a halt address after which only bubbles issue.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   bus        instruction_fetch_if.master (control in, memory address out,
//              memory word in, IF/ID register and status out)
//
// Parameters:
//   ADDR_W     PC / memory address width in words
//   DATA_W     instruction width
//   RESET_PC   PC value after reset
//   HALT_ADDR  fetching this address enters HALT after the word is latched
//   NOP_WORD   bubble encoding placed in IF/ID when no real fetch happens
//
// Configuration macro:
//   FETCH_COUNT_EN  when defined, builds a saturating 16-bit counter of valid
//                   fetches on FetchCount; otherwise FetchCount is tied to 0.
// ---------------------------------------------------------------------------
module instruction_fetch #(
  parameter int                 ADDR_W    = 10,
  parameter int                 DATA_W    = 32,
  parameter int                 RESET_PC  = 0,
  parameter int                 HALT_ADDR = 1023,
  parameter logic [DATA_W-1:0]  NOP_WORD  = 32'h41E00000
) (
  input  logic                 clk,
  input  logic                 rst,
  instruction_fetch_if.master  bus
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  // What this edge does to PC and IF/ID, already resolved by priority.
  typedef enum logic [2:0] {
    ACT_FETCH,
    ACT_BRANCH,
    ACT_BUBBLE_HOLD,
    ACT_HOLD,
    ACT_FLUSH,
    ACT_HALTED
  } action_t;

  localparam logic [ADDR_W-1:0] RESET_PC_W  = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] HALT_ADDR_W = ADDR_W'(HALT_ADDR);

  state_t            state_q,     state_d;
  logic [ADDR_W-1:0] pc_q,        pc_d;
  logic [DATA_W-1:0] ifIdInstr_q, ifIdInstr_d;
  logic [ADDR_W-1:0] ifIdPc_q,    ifIdPc_d;
  logic              ifIdValid_q, ifIdValid_d;
  logic              halted_q,    halted_d;

  logic [ADDR_W-1:0] pcPlus1;
  action_t           action;

  // The adder is ADDR_W bits wide, so the last word wraps to address 0.
  assign pcPlus1 = pc_q + ADDR_W'(1);

  // Memory read is combinational: the address is simply the current PC.
  assign bus.Addr = pc_q;

  // Resolve the control inputs into a single action. A branch beats every
  // other request, stall+flush squashes without advancing, and once halted
  // every request is ignored.
  always_comb begin
    action = ACT_FETCH;
    if (state_q == HALT) begin
      action = ACT_HALTED;
    end else if (bus.BranchTaken) begin
      action = ACT_BRANCH;
    end else if (bus.Stall && bus.Flush) begin
      action = ACT_BUBBLE_HOLD;
    end else if (bus.Stall) begin
      action = ACT_HOLD;
    end else if (bus.Flush) begin
      action = ACT_FLUSH;
    end
  end

  // Next-state values for the PC, the IF/ID register and the run/halt state.
  // A bubble keeps the previous IfId_PC since decode ignores it when
  // IfId_Valid is low. The halting fetch latches its word normally but
  // leaves the PC parked on the halt address.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ifIdInstr_d = ifIdInstr_q;
    ifIdPc_d    = ifIdPc_q;
    ifIdValid_d = ifIdValid_q;
    halted_d    = halted_q;
    unique case (action)
      ACT_BRANCH: begin
        pc_d        = bus.BranchTarget;
        ifIdInstr_d = NOP_WORD;
        ifIdValid_d = 1'b0;
      end
      ACT_BUBBLE_HOLD: begin
        ifIdInstr_d = NOP_WORD;
        ifIdValid_d = 1'b0;
      end
      ACT_HOLD: begin
      end
      ACT_FLUSH: begin
        pc_d        = pcPlus1;
        ifIdInstr_d = NOP_WORD;
        ifIdValid_d = 1'b0;
      end
      ACT_FETCH: begin
        ifIdInstr_d = bus.Instruction;
        ifIdPc_d    = pcPlus1;
        ifIdValid_d = 1'b1;
        if (pc_q == HALT_ADDR_W) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end else begin
          pc_d = pcPlus1;
        end
      end
      ACT_HALTED: begin
        ifIdInstr_d = NOP_WORD;
        ifIdValid_d = 1'b0;
      end
      default: begin
      end
    endcase
  end

  // All architectural state, including the FSM state and its registered
  // Halted output, updates here. Reset is asynchronous so it takes effect
  // even in the middle of a stalled or halted cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC_W;
      ifIdInstr_q <= NOP_WORD;
      ifIdPc_q    <= '0;
      ifIdValid_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ifIdInstr_q <= ifIdInstr_d;
      ifIdPc_q    <= ifIdPc_d;
      ifIdValid_q <= ifIdValid_d;
      halted_q    <= halted_d;
    end
  end

  assign bus.IfId_Instr = ifIdInstr_q;
  assign bus.IfId_PC    = ifIdPc_q;
  assign bus.IfId_Valid = ifIdValid_q;
  assign bus.Halted     = halted_q;

`ifdef FETCH_COUNT_EN
  logic [15:0] fetchCount_q;

  // Counts every edge that loads a real instruction into IF/ID, sticking at
  // all-ones rather than wrapping so a long run never reads back as small.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetchCount_q <= '0;
    end else if (action == ACT_FETCH && fetchCount_q != 16'hFFFF) begin
      fetchCount_q <= fetchCount_q + 16'd1;
    end
  end

  assign bus.FetchCount = fetchCount_q;
`else
  assign bus.FetchCount = 16'd0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
//
// Purpose:
//   Directed bench for instruction_fetch. A memory model returns word == address.
//   A table of per-cycle control inputs with hand-computed expected outputs
//   covers free-run, stall, branch-under-stall, flush, stall+flush, wrap, a
//   flush on the halt address, halting and ignored controls in HALT. Hand
//   sequences cover an asynchronous reset while halted, a second instance
//   (RESET_PC=1020, HALT_ADDR=0) that wraps 1023->0, and the fetch counter.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

  localparam int          ADDR_W = 10;
  localparam int          DATA_W = 32;
  localparam logic [31:0] NOP    = 32'h41E00000;

`ifdef FETCH_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk;
  logic rst;

  int errors;
  int checks;

  instruction_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus  ();
  instruction_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) busB ();

  instruction_fetch #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(0), .HALT_ADDR(1023), .NOP_WORD(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  instruction_fetch #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(1020), .HALT_ADDR(0), .NOP_WORD(NOP)
  ) dutB (
    .clk(clk),
    .rst(rst),
    .bus(busB)
  );

  // Memory model: every word holds its own address.
  assign bus.Instruction  = DATA_W'(bus.Addr);
  assign busB.Instruction = DATA_W'(busB.Addr);

  // The second instance only free-runs.
  assign busB.Stall        = 1'b0;
  assign busB.Flush        = 1'b0;
  assign busB.BranchTaken  = 1'b0;
  assign busB.BranchTarget = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              stall;
    logic              flush;
    logic              br;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] expAddr;
    logic [31:0]       expInstr;
    logic              chkPc;
    logic [ADDR_W-1:0] expPc;
    logic              expValid;
    logic              expHalted;
    int                expCnt;
  } vec_t;

  vec_t vecs[23];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic f, input logic b, input logic [ADDR_W-1:0] t);
    bus.Stall        = s;
    bus.Flush        = f;
    bus.BranchTaken  = b;
    bus.BranchTarget = t;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " Addr"},       32'(bus.Addr), 32'd0);
    checkOutput({tag, " IfId_Instr"}, bus.IfId_Instr, NOP);
    checkOutput({tag, " IfId_PC"},    32'(bus.IfId_PC), 32'd0);
    checkOutput({tag, " IfId_Valid"}, 32'(bus.IfId_Valid), 32'd0);
    checkOutput({tag, " Halted"},     32'(bus.Halted), 32'd0);
    checkOutput({tag, " FetchCount"}, 32'(bus.FetchCount), 32'd0);
    checkOutput({tag, " B Addr"},     32'(busB.Addr), 32'd1020);
  endtask

  logic [ADDR_W-1:0] bAddr[6];
  logic [31:0]       bInstr[6];
  logic [ADDR_W-1:0] bPc[6];
  logic              bValid[6];
  logic              bHalted[6];
  logic [1:0]        seq[13];

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, '0);

    //            s    f    b    tgt   addr  instr  chk  pc    v    h    cnt
    vecs[0]  = '{1'b0,1'b0,1'b0,10'd0,   10'd1,   32'd0,   1'b1,10'd1,   1'b1,1'b0,1};
    vecs[1]  = '{1'b0,1'b0,1'b0,10'd0,   10'd2,   32'd1,   1'b1,10'd2,   1'b1,1'b0,2};
    vecs[2]  = '{1'b0,1'b0,1'b0,10'd0,   10'd3,   32'd2,   1'b1,10'd3,   1'b1,1'b0,3};
    vecs[3]  = '{1'b0,1'b0,1'b0,10'd0,   10'd4,   32'd3,   1'b1,10'd4,   1'b1,1'b0,4};
    vecs[4]  = '{1'b0,1'b0,1'b0,10'd0,   10'd5,   32'd4,   1'b1,10'd5,   1'b1,1'b0,5};
    vecs[5]  = '{1'b1,1'b0,1'b0,10'd0,   10'd5,   32'd4,   1'b1,10'd5,   1'b1,1'b0,5};
    vecs[6]  = '{1'b1,1'b0,1'b0,10'd0,   10'd5,   32'd4,   1'b1,10'd5,   1'b1,1'b0,5};
    vecs[7]  = '{1'b1,1'b0,1'b0,10'd0,   10'd5,   32'd4,   1'b1,10'd5,   1'b1,1'b0,5};
    vecs[8]  = '{1'b0,1'b0,1'b0,10'd0,   10'd6,   32'd5,   1'b1,10'd6,   1'b1,1'b0,6};
    vecs[9]  = '{1'b0,1'b0,1'b0,10'd0,   10'd7,   32'd6,   1'b1,10'd7,   1'b1,1'b0,7};
    vecs[10] = '{1'b1,1'b0,1'b1,10'd20,  10'd20,  NOP,     1'b0,10'd0,   1'b0,1'b0,7};
    vecs[11] = '{1'b0,1'b0,1'b0,10'd0,   10'd21,  32'd20,  1'b1,10'd21,  1'b1,1'b0,8};
    vecs[12] = '{1'b0,1'b1,1'b0,10'd0,   10'd22,  NOP,     1'b0,10'd0,   1'b0,1'b0,8};
    vecs[13] = '{1'b1,1'b1,1'b0,10'd0,   10'd22,  NOP,     1'b0,10'd0,   1'b0,1'b0,8};
    vecs[14] = '{1'b0,1'b0,1'b0,10'd0,   10'd23,  32'd22,  1'b1,10'd23,  1'b1,1'b0,9};
    vecs[15] = '{1'b0,1'b1,1'b1,10'd1021,10'd1021,NOP,     1'b0,10'd0,   1'b0,1'b0,9};
    vecs[16] = '{1'b0,1'b0,1'b0,10'd0,   10'd1022,32'd1021,1'b1,10'd1022,1'b1,1'b0,10};
    vecs[17] = '{1'b0,1'b0,1'b0,10'd0,   10'd1023,32'd1022,1'b1,10'd1023,1'b1,1'b0,11};
    vecs[18] = '{1'b0,1'b1,1'b0,10'd0,   10'd0,   NOP,     1'b0,10'd0,   1'b0,1'b0,11};
    vecs[19] = '{1'b0,1'b0,1'b1,10'd1023,10'd1023,NOP,     1'b0,10'd0,   1'b0,1'b0,11};
    vecs[20] = '{1'b0,1'b0,1'b0,10'd0,   10'd1023,32'd1023,1'b1,10'd0,   1'b1,1'b1,12};
    vecs[21] = '{1'b0,1'b0,1'b0,10'd0,   10'd1023,NOP,     1'b0,10'd0,   1'b0,1'b1,12};
    vecs[22] = '{1'b1,1'b1,1'b1,10'd5,   10'd1023,NOP,     1'b0,10'd0,   1'b0,1'b1,12};

    bAddr   = '{10'd1021, 10'd1022, 10'd1023, 10'd0, 10'd0, 10'd0};
    bInstr  = '{32'd1020, 32'd1021, 32'd1022, 32'd1023, 32'd0, NOP};
    bPc     = '{10'd1021, 10'd1022, 10'd1023, 10'd0, 10'd1, 10'd1};
    bValid  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bHalted = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    // 0 fetch, 1 flush, 2 stall: 10 fetches, 2 flushes, 1 stall.
    seq = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0};

    repeat (2) @(posedge clk);
    #1;
    checkResetState("reset");
    @(negedge clk);
    rst = 1'b0;

    // Table-driven main sequence.
    for (int i = 0; i < 23; i++) begin
      applyStimulus(vecs[i].stall, vecs[i].flush, vecs[i].br, vecs[i].target);
      tick();
      checkOutput($sformatf("row%0d Addr", i),       32'(bus.Addr),       32'(vecs[i].expAddr));
      checkOutput($sformatf("row%0d IfId_Instr", i), bus.IfId_Instr,       vecs[i].expInstr);
      checkOutput($sformatf("row%0d IfId_Valid", i), 32'(bus.IfId_Valid), 32'(vecs[i].expValid));
      checkOutput($sformatf("row%0d Halted", i),     32'(bus.Halted),     32'(vecs[i].expHalted));
      checkOutput($sformatf("row%0d FetchCount", i), 32'(bus.FetchCount),
                  CNT_EN ? 32'(vecs[i].expCnt) : 32'd0);
      if (vecs[i].chkPc)
        checkOutput($sformatf("row%0d IfId_PC", i), 32'(bus.IfId_PC), 32'(vecs[i].expPc));
    end

    // Asynchronous reset while halted, with no clock edge in between.
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    #2;
    rst = 1'b1;
    #1;
    checkResetState("async");
    @(negedge clk);
    rst = 1'b0;

    // Restart from 0 on the main instance; second instance wraps and halts.
    for (int k = 0; k < 6; k++) begin
      tick();
      checkOutput($sformatf("restart%0d Instr", k), bus.IfId_Instr, 32'(k));
      checkOutput($sformatf("restart%0d PC", k),    32'(bus.IfId_PC), 32'(k + 1));
      checkOutput($sformatf("restart%0d Valid", k), 32'(bus.IfId_Valid), 32'd1);
      checkOutput($sformatf("wrapB%0d Addr", k),    32'(busB.Addr), 32'(bAddr[k]));
      checkOutput($sformatf("wrapB%0d Instr", k),   busB.IfId_Instr, bInstr[k]);
      checkOutput($sformatf("wrapB%0d Valid", k),   32'(busB.IfId_Valid), 32'(bValid[k]));
      checkOutput($sformatf("wrapB%0d Halted", k),  32'(busB.Halted), 32'(bHalted[k]));
      if (k < 5)
        checkOutput($sformatf("wrapB%0d PC", k), 32'(busB.IfId_PC), 32'(bPc[k]));
    end

    // Fetch counter: 10 real fetches among flushes and a stall.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int k = 0; k < 13; k++) begin
      applyStimulus(seq[k] == 2'd2, seq[k] == 2'd1, 1'b0, '0);
      tick();
    end
    checkOutput("count FetchCount", 32'(bus.FetchCount), CNT_EN ? 32'd10 : 32'd0);
    checkOutput("count Addr",       32'(bus.Addr), 32'd12);
    checkOutput("count IfId_Instr", bus.IfId_Instr, 32'd11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
